// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-way round-robin arbiter with registered owner index.
// Optional forced rotation on long tenures when GRANT_TIMEOUT_EN is defined.
module decoder2to4 (
  input  logic       en,
  input  logic [1:0] idx,
  output logic [3:0] y
);
  always_comb begin
    y = '0;
    if (en) y[idx] = 1'b1;
  end
endmodule

module rr_arbiter4 #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout_pulse
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] pick_idx;
  logic       any_req;
  logic       own_req;
  logic       force_rot;

  generate
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255 ||
        (2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_bad_cfg
      $error("rr_arbiter4: illegal TIMEOUT_CYCLES/CNT_W");
    end
  endgenerate

  // First requester at or after p, wrapping modulo 4.
  function automatic logic [1:0] pick(
    input logic [3:0] r,
    input logic [1:0] p
  );
    logic [1:0] k;
    pick = p;
    for (int i = 3; i >= 0; i--) begin
      k = p + 2'(i);
      if (r[k]) pick = k;
    end
  endfunction

  assign any_req  = |req;
  assign own_req  = req[idx_q];
  assign pick_idx = pick(req, ptr_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  // In GRANT, ptr_q is always owner+1, so pick never
  // returns the owner while anyone else is asking.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          idx_d   = pick_idx;
          ptr_d   = pick_idx + 2'd1;
        end
      end
      GRANT: begin
        if (!own_req || force_rot) begin
          if (any_req) begin
            idx_d = pick_idx;
            ptr_d = pick_idx + 2'd1;
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  assign grant_valid = (state_q == GRANT);
  assign grant_idx   = idx_q;

  decoder2to4 u_dec (
    .en  (grant_valid),
    .idx (idx_q),
    .y   (grant)
  );

`ifdef GRANT_TIMEOUT_EN
  localparam logic [CNT_W-1:0] SAT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             pulse_q;
  logic             others;
  logic             load;

  assign others    = |(req & ~grant);
  assign force_rot = (state_q == GRANT) && own_req &&
                     others && (cnt_q == SAT);
  assign load      = (state_q == IDLE) ? any_req
                                       : (!own_req || force_rot);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= force_rot;
      if (load)
        cnt_q <= '0;
      else if (state_q == GRANT && cnt_q != SAT)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign timeout_pulse = pulse_q;
`else
  assign force_rot     = 1'b0;
  assign timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter4.sv
// Scoreboard bench for rr_arbiter4: model predicts per edge,
// negedge monitor pops and compares.
module tb_rr_arbiter4;

  localparam int TCYC = 4;
`ifdef GRANT_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       timeout_pulse;

  rr_arbiter4 #(.TIMEOUT_CYCLES(TCYC), .CNT_W(8)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req           (req),
    .grant         (grant),
    .grant_idx     (grant_idx),
    .grant_valid   (grant_valid),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] g;
    logic       v;
    logic [1:0] i;
    logic       p;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  bit m_v;
  int m_idx;
  int m_ptr;
  int m_cnt;

  task automatic cmp(input string name, input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return 0;
  endfunction

  task automatic give(input logic [3:0] r, input int from);
    m_idx = pick(r, from);
    m_ptr = (m_idx + 1) % 4;
    m_cnt = 0;
  endtask

  task automatic model_reset();
    m_v = 0; m_idx = 0; m_ptr = 0; m_cnt = 0;
  endtask

  // One clock edge with request vector r; expected outcome queued.
  task automatic step(input logic [3:0] r);
    exp_t e;
    bit   pulse;
    logic [3:0] others;
    req = r;
    @(posedge clk);
    pulse = 0;
    if (!m_v) begin
      if (r != 0) begin
        m_v = 1;
        give(r, m_ptr);
      end
    end else if (r[m_idx]) begin
      others = r & ~(4'(1) << m_idx);
      if (TO && m_cnt == TCYC - 1 && others != 0) begin
        give(r, (m_idx + 1) % 4);
        pulse = 1;
      end else if (m_cnt < TCYC - 1) begin
        m_cnt++;
      end
    end else if (r != 0) begin
      give(r, (m_idx + 1) % 4);
    end else begin
      m_v = 0;
    end
    e.g = m_v ? 4'(4'(1) << m_idx) : 4'b0000;
    e.v = m_v;
    e.i = 2'(m_idx);
    e.p = pulse;
    q.push_back(e);
    #1;
  endtask

  // Asserts reset between edges and checks it acts before the next edge.
  task automatic mid_reset();
    #2;
    reset_n = 1'b0;
    q.delete();
    model_reset();
    #1;
    cmp("rst_grant", grant, 4'b0000);
    cmp("rst_valid", {3'b0, grant_valid}, 4'b0000);
    cmp("rst_pulse", {3'b0, timeout_pulse}, 4'b0000);
    #1;
    reset_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp("grant", grant, e.g);
      cmp("grant_valid", {3'b0, grant_valid}, {3'b0, e.v});
      if (e.v) cmp("grant_idx", {2'b0, grant_idx}, {2'b0, e.i});
      cmp("timeout_pulse", {3'b0, timeout_pulse}, {3'b0, e.p});
    end
  end

  logic [3:0] r;
  int         seq[4];

  initial begin
    model_reset();
    req = 4'b1111;
    #3;
    cmp("rst_grant", grant, 4'b0000);
    cmp("rst_valid", {3'b0, grant_valid}, 4'b0000);
    @(posedge clk);
    #1;
    cmp("rst_hold_grant", grant, 4'b0000);
    reset_n = 1'b1;

    // Full contention; each owner drops for one cycle in turn.
    step(4'b1111);
    for (int k = 0; k < 5; k++) begin
      step(4'b1111 & ~(4'(1) << (k % 4)));
      step(4'b1111);
    end

    // Single requester, then release.
    step(4'b0000);
    step(4'b0100);
    step(4'b0100);
    step(4'b0000);
    step(4'b0000);

    // Owner 2, then asynchronous reset mid-cycle.
    step(4'b0100);
    mid_reset();
    step(4'b1000);
    step(4'b0000);

    // Two holders for a long time: rotation only with the timeout.
    for (int k = 0; k < 100; k++) step(4'b0011);
    step(4'b0000);

    // Lone holder never rotates away.
    for (int k = 0; k < 12; k++) step(4'b0100);
    step(4'b0000);

    // Random level-style requests with occasional resets.
    r = 4'b0000;
    for (int k = 0; k < 600; k++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      if ($urandom_range(0, 150) == 0) mid_reset();
      step(r);
    end

    step(4'b0000);
    step(4'b0000);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
